ec_dmem_ctrl: RTL and testbench
===============================

Name: ec_dmem_ctrl

Overview:
- Data-memory access controller for the EC (exception-commit) stage. It sits directly downstream of the EX→EC pipeline register and consumes that register's request, load and store fields.
- Drives the SRAM-like data bus (req / addr_ok / data_ok), stalls the pipeline until the access completes, and returns aligned, extended load data to WB.
- Discards responses that belong to accesses flushed by refresh.

Parameters:
- AW, 32, address width.
- DW, 32, data width (fixed at 32; the parameter exists only for documentation).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- refresh  in  1  pipeline flush (exception/eret), same signal that clears the EC register
- wb_stall  in  1  downstream stall from other sources; must not depend on mem_stall
- ec_data_req  in  1  EC instruction is a load/store
- ec_ex_any  in  1  EC instruction carries an exception; suppresses the access
- ec_load  in  1  1 = load, 0 = store
- ec_loadX  in  1  1 = zero-extend load, 0 = sign-extend load
- ec_lsV  in  4  byte-lane enable: 0001/0010/0100/1000 = byte, 0011/1100 = half, 1111 = word
- ec_res  in  32  effective address
- ec_B  in  32  store data, right-justified
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address (= ec_res)
- data_wdata  out  32  lane-aligned store data
- data_addr_ok  in  1  address handshake
- data_data_ok  in  1  data handshake
- data_rdata  in  32  read data
- mem_stall  out  1  hold the EC stage
- load_data  out  32  aligned, extended load result
- load_valid  out  1  load_data is valid for the current EC instruction

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN. Registered: state, buffered rdata, kill flag.
- Reset: state = IDLE, kill = 0, data_req = 0, mem_stall = 0, load_valid = 0, load_data = 0.
- IDLE:
  - if ec_data_req && !ec_ex_any && !refresh, assert data_req combinationally in the same cycle and go to REQ behaviour that cycle (data_req seen in IDLE).
  - addr_ok in that same cycle → WAIT; otherwise → REQ.
  - mem_stall = 1 whenever a valid request is present and not yet done.
- REQ: data_req held high and address/wr/size/wdata held stable until data_addr_ok; then → WAIT.
- WAIT: data_req = 0. On data_data_ok, capture data_rdata and → DONE. data_ok arriving in the same cycle as addr_ok is allowed: REQ/IDLE go straight to DONE.
- DONE:
  - mem_stall = 0, load_valid = ec_load.
  - Stays in DONE while wb_stall = 1, so there is no re-issue while held.
  - → IDLE when !wb_stall, i.e. the instruction advances.
- Stores complete on data_ok exactly like loads; load_valid = 0 for stores.
- refresh handling:
  - in REQ: data_req stays asserted until addr_ok (a request is never withdrawn); set kill. After addr_ok → DRAIN.
  - in IDLE, or in REQ before any request is issued: no request is issued.
  - in WAIT without data_ok that cycle: → DRAIN.
  - in WAIT with data_ok that cycle, or in DONE: → IDLE, data dropped.
- DRAIN: mem_stall = 0 (the pipeline already restarts); data_req = 0 until data_ok, then → IDLE. A new request is presented only once the state is back in IDLE; a new EC request waits with mem_stall = 1.
- Invariant: at most one outstanding transaction.
- data_size decode from ec_lsV: 1111 → 2; 0011/1100 → 1; else → 0.
- data_wdata = ec_B << (8 × ec_res[1:0]).
- load_data = buffered rdata >> (8 × ec_res[1:0]), then masked to size. Sign-extend from bit 7/15 when loadX = 0, zero-extend when loadX = 1. Word loads are passed through.
- Misaligned addresses never reach this block; they are flagged in EX via ec_ex_any.

Decomposition:
- Shared package/header:
  - state encodings (EC_MEM_IDLE … EC_MEM_DRAIN, 3 bits)
  - size constants (SZ_B = 0, SZ_H = 1, SZ_W = 2)
- One natural sub-module: ec_load_align. It is combinational and takes rdata, offset, size and loadX, producing load_data. It is reused by the tests.

Test Plan:
- lb: addr 0x1000_0003, lsV = 1000, loadX = 0; rdata = 0x80_11_22_33, addr_ok after 2 cycles, data_ok after 3 more → size = 0, load_data = 0xFFFF_FF80, mem_stall high for exactly the 5 wait cycles.
- lhu: addr 0x…2, lsV = 1100, loadX = 1, rdata = 0xBEEF_1234 → load_data = 0x0000_BEEF.
- sw: ec_B = 0xDEAD_BEEF, addr_ok and data_ok in the same cycle as req → data_wr = 1, size = 2, wdata = 0xDEAD_BEEF, single-cycle stall, load_valid = 0.
- sb: addr 0x…1, ec_B = 0x0000_00AB → wdata = 0x0000_AB00.
- refresh in WAIT: then data_ok arrives 4 cycles later while a new load is in EC → first data discarded (DRAIN); second request is issued only after that data_ok and returns its own data.
- wb_stall = 1 for 3 cycles in DONE → no second data_req; load_data stable; → IDLE on release.
- ec_ex_any = 1 with ec_data_req = 1 → no data_req, mem_stall = 0.
- Reset asserted in WAIT → next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/ec_dmem_ctrl_pkg.sv
// Shared types and constants for the EC-stage data-memory controller.
package ec_dmem_ctrl_pkg;

  typedef enum logic [2:0] {
    EC_MEM_IDLE  = 3'd0,
    EC_MEM_REQ   = 3'd1,
    EC_MEM_WAIT  = 3'd2,
    EC_MEM_DONE  = 3'd3,
    EC_MEM_DRAIN = 3'd4
  } ec_mem_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Byte-lane enable to bus size: full word, either half, otherwise byte.
  function automatic logic [1:0] lsv_to_size(input logic [3:0] lsv);
    logic [1:0] sz;
    case (lsv)
      4'b1111:          sz = SZ_W;
      4'b0011, 4'b1100: sz = SZ_H;
      default:          sz = SZ_B;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/ec_dmem_ctrl_align.sv
// Load data alignment: shift the addressed lane down, then sign/zero extend.
module ec_load_align
  import ec_dmem_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_loadx,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  // Mask to the access size and extend; loadx = 1 means zero-extend.
  always_comb begin
    o_data = w_shifted;
    case (i_size)
      SZ_B:    o_data = i_loadx ? {24'd0, w_shifted[7:0]}
                                : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_data = i_loadx ? {16'd0, w_shifted[15:0]}
                                : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ec_dmem_ctrl.sv
// EC-stage data-memory controller: drives the SRAM-like bus, stalls the
// pipeline until the access completes and drops responses of flushed accesses.
//
// Bus handshake: data_req is held with stable addr/wr/size/wdata until a
// cycle with data_addr_ok; one data_data_ok later completes it (it may come in
// the same cycle as data_addr_ok). A request is never withdrawn, and at most
// one transaction is outstanding.
module ec_dmem_ctrl
  import ec_dmem_ctrl_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          refresh,
  input  logic          wb_stall,
  input  logic          ec_data_req,
  input  logic          ec_ex_any,
  input  logic          ec_load,
  input  logic          ec_loadX,
  input  logic [3:0]    ec_lsV,
  input  logic [AW-1:0] ec_res,
  input  logic [DW-1:0] ec_B,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata,
  output logic          mem_stall,
  output logic [DW-1:0] load_data,
  output logic          load_valid,
  output logic [2:0]    dbg_state
);

  ec_mem_state_e r_state;
  ec_mem_state_e w_next;
  logic          r_kill;
  logic          w_kill_next;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_addr;
  logic          r_wr;
  logic [1:0]    r_size;
  logic [DW-1:0] r_wdata;

  logic          w_valid_req;
  logic          w_killed;
  logic          w_issue;
  logic          w_capture;
  logic          w_data_req;
  logic          w_mem_stall;
  logic          w_load_valid;
  logic [DW-1:0] w_wdata_now;

  assign w_valid_req = ec_data_req && !ec_ex_any;
  assign w_killed    = r_kill || refresh;
  assign w_wdata_now = ec_B << {ec_res[1:0], 3'b000};

  // Next-state and handshake outputs; outputs stay idle while reset is low.
  always_comb begin
    w_next       = r_state;
    w_kill_next  = 1'b0;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    w_data_req   = 1'b0;
    w_mem_stall  = 1'b0;
    w_load_valid = 1'b0;
    if (resetn) begin
      case (r_state)
        EC_MEM_IDLE: begin
          if (w_valid_req && !refresh) begin
            w_data_req  = 1'b1;
            w_mem_stall = 1'b1;
            w_issue     = 1'b1;
            if (data_addr_ok) begin
              if (data_data_ok) begin
                w_next    = EC_MEM_DONE;
                w_capture = 1'b1;
              end else begin
                w_next = EC_MEM_WAIT;
              end
            end else begin
              w_next = EC_MEM_REQ;
            end
          end
        end
        EC_MEM_REQ: begin
          w_data_req  = 1'b1;
          // Once killed, only a fresh EC request waiting behind us stalls.
          w_mem_stall = w_killed ? (w_valid_req && !refresh) : 1'b1;
          if (data_addr_ok) begin
            if (data_data_ok) begin
              if (w_killed) begin
                w_next = EC_MEM_IDLE;
              end else begin
                w_next    = EC_MEM_DONE;
                w_capture = 1'b1;
              end
            end else begin
              w_next = w_killed ? EC_MEM_DRAIN : EC_MEM_WAIT;
            end
          end else begin
            w_kill_next = w_killed;
          end
        end
        EC_MEM_WAIT: begin
          if (refresh) begin
            w_next = data_data_ok ? EC_MEM_IDLE : EC_MEM_DRAIN;
          end else begin
            w_mem_stall = 1'b1;
            if (data_data_ok) begin
              w_next    = EC_MEM_DONE;
              w_capture = 1'b1;
            end
          end
        end
        EC_MEM_DONE: begin
          w_load_valid = ec_load;
          if (refresh || !wb_stall) w_next = EC_MEM_IDLE;
        end
        EC_MEM_DRAIN: begin
          w_mem_stall = w_valid_req && !refresh;
          if (data_data_ok) w_next = EC_MEM_IDLE;
        end
        default: w_next = EC_MEM_IDLE;
      endcase
    end
  end

  // State, kill flag, read-data buffer and held bus fields.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= EC_MEM_IDLE;
      r_kill  <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_size  <= SZ_B;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_kill  <= w_kill_next;
      if (w_capture) r_rdata <= data_rdata;
      if (w_issue) begin
        r_addr  <= ec_res;
        r_wr    <= !ec_load;
        r_size  <= lsv_to_size(ec_lsV);
        r_wdata <= w_wdata_now;
      end
    end
  end

  // In IDLE the bus shows the live EC fields; afterwards the held copy, so a
  // flush that clears the EC register cannot disturb a pending request.
  always_comb begin
    if (r_state == EC_MEM_IDLE) begin
      data_addr  = ec_res;
      data_wr    = !ec_load;
      data_size  = lsv_to_size(ec_lsV);
      data_wdata = w_wdata_now;
    end else begin
      data_addr  = r_addr;
      data_wr    = r_wr;
      data_size  = r_size;
      data_wdata = r_wdata;
    end
  end

  assign data_req   = w_data_req;
  assign mem_stall  = w_mem_stall;
  assign load_valid = w_load_valid;
  assign dbg_state  = r_state;

  ec_load_align u_align (
    .i_rdata  (r_rdata),
    .i_offset (ec_res[1:0]),
    .i_size   (lsv_to_size(ec_lsV)),
    .i_loadx  (ec_loadX),
    .o_data   (load_data)
  );

endmodule

// File: tb/tb_ec_dmem_ctrl.sv
// Bench for ec_dmem_ctrl: directed scenarios plus randomized accesses checked
// against an arithmetic model of load/store lane handling.
module tb_ec_dmem_ctrl;
  import ec_dmem_ctrl_pkg::*;

  // clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        refresh = 1'b0;
  logic        wb_stall = 1'b0;
  logic        ec_data_req = 1'b0;
  logic        ec_ex_any = 1'b0;
  logic        ec_load = 1'b0;
  logic        ec_loadX = 1'b0;
  logic [3:0]  ec_lsV = 4'b1111;
  logic [31:0] ec_res = '0;
  logic [31:0] ec_B = '0;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ec_dmem_ctrl #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn), .refresh(refresh), .wb_stall(wb_stall),
    .ec_data_req(ec_data_req), .ec_ex_any(ec_ex_any), .ec_load(ec_load),
    .ec_loadX(ec_loadX), .ec_lsV(ec_lsV), .ec_res(ec_res), .ec_B(ec_B),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .mem_stall(mem_stall), .load_data(load_data),
    .load_valid(load_valid), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: byte count, lane from address, plain arithmetic
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] addr,
                                         input logic [3:0] lsv, input logic zx);
    logic [63:0] v;
    logic [63:0] span;
    int n;
    int lane;
    n    = $countones(lsv);
    lane = int'(addr % 4);
    v    = {32'd0, rd} / (64'd1 << (8 * lane));
    span = 64'd1 << (8 * n);
    v    = v % span;
    if (!zx && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] b, input logic [31:0] addr);
    logic [63:0] p;
    p = {32'd0, b} * (64'd1 << (8 * int'(addr % 4)));
    return p[31:0];
  endfunction

  function automatic logic [1:0] m_size(input logic [3:0] lsv);
    int n;
    n = $countones(lsv);
    return (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
  endfunction

  task automatic set_ec(input logic ld, input logic zx, input logic [3:0] lsv,
                        input logic [31:0] addr, input logic [31:0] b);
    ec_data_req = 1'b1; ec_ex_any = 1'b0; ec_load = ld; ec_loadX = zx;
    ec_lsV = lsv; ec_res = addr; ec_B = b;
  endtask

  // driver: one access, addr_ok a_lat cycles after the first request cycle,
  // data_ok d_lat cycles after addr_ok, then hold cycles of wb_stall in DONE
  task automatic do_access(input string tag, input logic ld, input logic zx,
                           input logic [3:0] lsv, input logic [31:0] addr,
                           input logic [31:0] b, input logic [31:0] rd,
                           input int a_lat, input int d_lat, input int hold);
    int stall_cnt = 0;
    logic [31:0] exp_ld;
    exp_ld = m_load(rd, addr, lsv, zx);
    for (int k = 0; k <= a_lat + d_lat; k++) begin
      @(posedge clk); #1;
      set_ec(ld, zx, lsv, addr, b);
      refresh = 1'b0; wb_stall = 1'b0;
      data_addr_ok = (k == a_lat);
      data_data_ok = (k == a_lat + d_lat);
      data_rdata   = (k == a_lat + d_lat) ? rd : $urandom;
      @(negedge clk);
      chk({tag, ".req"}, {31'd0, data_req}, {31'd0, k <= a_lat});
      if (mem_stall) stall_cnt++;
      if (k <= a_lat) begin
        chk({tag, ".addr"}, data_addr, addr);
        chk({tag, ".wr"}, {31'd0, data_wr}, {31'd0, !ld});
        chk({tag, ".size"}, {30'd0, data_size}, {30'd0, m_size(lsv)});
        if (!ld) chk({tag, ".wdata"}, data_wdata, m_wdata(b, addr));
      end
    end
    chk({tag, ".stall_cycles"}, stall_cnt, a_lat + d_lat + 1);
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      wb_stall = (h < hold);
      @(negedge clk);
      chk({tag, ".done_req"}, {31'd0, data_req}, 32'd0);
      chk({tag, ".done_stall"}, {31'd0, mem_stall}, 32'd0);
      chk({tag, ".load_valid"}, {31'd0, load_valid}, {31'd0, ld});
      if (ld) chk({tag, ".load_data"}, load_data, exp_ld);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    ec_data_req = 1'b0; ec_ex_any = 1'b0; refresh = 1'b0; wb_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    chk("idle.state", {29'd0, dbg_state}, {29'd0, EC_MEM_IDLE});
  endtask

  logic [3:0]  lsv_tab [7];
  logic [1:0]  off_tab [7];
  logic [31:0] ra, rb, rr;
  int          sel;

  initial begin
    lsv_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    off_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};

    // reset
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.state", {29'd0, dbg_state}, {29'd0, EC_MEM_IDLE});
    chk("rst.req", {31'd0, data_req}, 32'd0);
    chk("rst.stall", {31'd0, mem_stall}, 32'd0);
    chk("rst.load_valid", {31'd0, load_valid}, 32'd0);
    chk("rst.load_data", load_data, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // directed accesses
    do_access("lb", 1'b1, 1'b0, 4'b1000, 32'h1000_0003, 32'h0, 32'h8011_2233, 1, 3, 0);
    do_access("lhu", 1'b1, 1'b1, 4'b1100, 32'h1000_0012, 32'h0, 32'hBEEF_1234, 1, 1, 0);
    do_access("sw", 1'b0, 1'b0, 4'b1111, 32'h1000_0020, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    do_access("sb", 1'b0, 1'b0, 4'b0010, 32'h1000_0031, 32'h0000_00AB, 32'h0, 0, 2, 0);
    do_access("lw_hold", 1'b1, 1'b0, 4'b1111, 32'h1000_0040, 32'h0, 32'h1234_5678, 0, 1, 3);
    go_idle();

    // exception suppresses the access; refresh in IDLE issues nothing
    @(posedge clk); #1;
    set_ec(1'b1, 1'b0, 4'b1111, 32'h2000_0000, 32'h0);
    ec_ex_any = 1'b1;
    @(negedge clk);
    chk("exany.req", {31'd0, data_req}, 32'd0);
    chk("exany.stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    ec_ex_any = 1'b0; refresh = 1'b1;
    @(negedge clk);
    chk("rfidle.req", {31'd0, data_req}, 32'd0);
    chk("rfidle.stall", {31'd0, mem_stall}, 32'd0);
    go_idle();

    // refresh in WAIT: old data drained, new load issued after its data_ok
    @(posedge clk); #1;
    set_ec(1'b1, 1'b0, 4'b1111, 32'h3000_0000, 32'h0);
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("rfw.reqA", {31'd0, data_req}, 32'd1);
    @(posedge clk); #1;
    data_addr_ok = 1'b0; refresh = 1'b1;
    @(negedge clk);
    chk("rfw.wait_req", {31'd0, data_req}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      refresh = 1'b0;
      set_ec(1'b1, 1'b1, 4'b0011, 32'h3000_0104, 32'h0);
      data_data_ok = (c == 3);
      data_rdata   = (c == 3) ? 32'h7777_0000 : $urandom;
      @(negedge clk);
      chk("rfw.drain_req", {31'd0, data_req}, 32'd0);
      chk("rfw.drain_stall", {31'd0, mem_stall}, 32'd1);
    end
    do_access("rfw.B", 1'b1, 1'b1, 4'b0011, 32'h3000_0104, 32'h0, 32'hC0DE_9ABC, 0, 1, 0);
    go_idle();

    // refresh in REQ: request held stable until addr_ok, then drained
    ra = 32'h4000_0002; rb = 32'h0000_5A5A;
    @(posedge clk); #1;
    set_ec(1'b0, 1'b0, 4'b1100, ra, rb);
    @(negedge clk);
    chk("rfr.req0", {31'd0, data_req}, 32'd1);
    @(posedge clk); #1;
    refresh = 1'b1;
    @(negedge clk);
    chk("rfr.req1", {31'd0, data_req}, 32'd1);
    chk("rfr.addr1", data_addr, ra);
    @(posedge clk); #1;
    refresh = 1'b0; ec_data_req = 1'b0; ec_res = $urandom; ec_B = $urandom; ec_load = 1'b1;
    @(negedge clk);
    chk("rfr.req2", {31'd0, data_req}, 32'd1);
    chk("rfr.addr2", data_addr, ra);
    chk("rfr.wdata2", data_wdata, m_wdata(rb, ra));
    chk("rfr.wr2", {31'd0, data_wr}, 32'd1);
    chk("rfr.stall2", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("rfr.req3", {31'd0, data_req}, 32'd1);
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("rfr.drain_req", {31'd0, data_req}, 32'd0);
    chk("rfr.drain_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b1;
    @(negedge clk);
    chk("rfr.drain_ok_req", {31'd0, data_req}, 32'd0);
    go_idle();

    // randomized accesses
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 6);
      ra  = $urandom;
      ra[1:0] = off_tab[sel];
      rb  = $urandom;
      rr  = $urandom;
      do_access("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lsv_tab[sel],
                ra, rb, rr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
    go_idle();

    // reset while in WAIT
    @(posedge clk); #1;
    set_ec(1'b1, 1'b0, 4'b1111, 32'h5000_0000, 32'h0);
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; ec_data_req = 1'b0;
    @(negedge clk);
    chk("rstw.state", {29'd0, dbg_state}, {29'd0, EC_MEM_IDLE});
    chk("rstw.req", {31'd0, data_req}, 32'd0);
    chk("rstw.stall", {31'd0, mem_stall}, 32'd0);
    chk("rstw.load_valid", {31'd0, load_valid}, 32'd0);
    chk("rstw.load_data", load_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
